mem_port_arbiter: RTL

//  Shares one single-port, fixed-latency unified RAM between two requesters: instruction fetch (IF) and the MEM-stage load/store.

---
 rtl/mem_port_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, fixed-latency unified RAM between the
//               instruction-fetch (IF) port and the MEM-stage load/store port.
//               Each RAM access is sequenced IDLE -> ISSUE -> WAIT -> DONE,
//               returning data together with a one-cycle ready pulse.
//               MEM has priority over IF when both request in IDLE.
// Ports       : clk, rst (sync, active-high)
//               if_req/if_addr -> if_rdata/if_ready           (IF side)
//               mem_r_en/mem_w_en/mem_addr/mem_wdata
//                                -> mem_rdata/mem_ready       (MEM side)
//               ram_en/ram_we/ram_addr/ram_wdata <- ram_rdata (RAM macro)
//               pipe_freeze  combinational freeze into the pipeline
//               stall_cnt/conflict_cnt  statistics counters
// Options     : MEM_ARB_STATS_EN - when defined, stall_cnt and conflict_cnt
//               are live saturating counters; otherwise both read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WORD_LEN     = 32,
    parameter int RAM_ADDR_LEN = 16,
    parameter int MEM_LATENCY  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [WORD_LEN-1:0]     if_addr,
    output logic [WORD_LEN-1:0]     if_rdata,
    output logic                    if_ready,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic [WORD_LEN-1:0]     mem_addr,
    input  logic [WORD_LEN-1:0]     mem_wdata,
    output logic [WORD_LEN-1:0]     mem_rdata,
    output logic                    mem_ready,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [RAM_ADDR_LEN-1:0] ram_addr,
    output logic [WORD_LEN-1:0]     ram_wdata,
    input  logic [WORD_LEN-1:0]     ram_rdata,
    output logic                    pipe_freeze,
    output logic [31:0]             stall_cnt,
    output logic [15:0]             conflict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The WAIT countdown ends on the cycle ram_rdata is valid, which is
    // MEM_LATENCY cycles after the ISSUE (ram_en) cycle.
    localparam logic [3:0] c_WAIT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                  state_q,     state_d;
    logic [3:0]              wait_cnt_q,  wait_cnt_d;
    logic                    grant_mem_q, grant_mem_d;   // 1: MEM owns access
    logic                    we_q,        we_d;          // access is a store
    logic                    ram_en_q,    ram_en_d;
    logic                    ram_we_q,    ram_we_d;
    logic [RAM_ADDR_LEN-1:0] ram_addr_q,  ram_addr_d;
    logic [WORD_LEN-1:0]     ram_wdata_q, ram_wdata_d;
    logic [WORD_LEN-1:0]     if_rdata_q,  if_rdata_d;
    logic                    if_ready_q,  if_ready_d;
    logic [WORD_LEN-1:0]     mem_rdata_q, mem_rdata_d;
    logic                    mem_ready_q, mem_ready_d;

    logic w_mem_req;
    logic w_freeze;
    logic w_unused_addr_bits;

    assign w_mem_req = mem_r_en | mem_w_en;
    assign w_freeze  = (if_req & ~if_ready_q) | (w_mem_req & ~mem_ready_q);

    // Byte-offset and above-RAM address bits are intentionally ignored.
    assign w_unused_addr_bits = ^{if_addr[WORD_LEN-1:RAM_ADDR_LEN+2], if_addr[1:0],
                                  mem_addr[WORD_LEN-1:RAM_ADDR_LEN+2], mem_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        grant_mem_d = grant_mem_q;
        we_d        = we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        // Strobes are single-cycle: default low, raised only on transitions.
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_mem_req) begin
                    grant_mem_d = 1'b1;
                    we_d        = mem_w_en;          // r_en & w_en -> store
                    ram_addr_d  = mem_addr[RAM_ADDR_LEN+1:2];
                    ram_wdata_d = mem_wdata;
                    ram_en_d    = 1'b1;
                    ram_we_d    = mem_w_en;
                    state_d     = ST_ISSUE;
                end else if (if_req) begin
                    grant_mem_d = 1'b0;
                    we_d        = 1'b0;
                    ram_addr_d  = if_addr[RAM_ADDR_LEN+1:2];
                    ram_en_d    = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = c_WAIT_LOAD;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    if (grant_mem_q) begin
                        if (!we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                        mem_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = ram_rdata;
                        if_ready_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            grant_mem_q <= 1'b0;
            we_q        <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            mem_rdata_q <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            grant_mem_q <= grant_mem_d;
            we_q        <= we_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_rdata_q <= mem_rdata_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign if_ready    = if_ready_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_ready   = mem_ready_q;
    assign pipe_freeze = w_freeze;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q,    stall_cnt_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (w_freeze && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((state_q == ST_IDLE) && w_mem_req && if_req && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`else
    assign stall_cnt    = 32'd0;
    assign conflict_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
